// File: rtl/player_anim_pkg.sv
// player_anim_pkg: shared state encoding, sprite indices and delta helper for player_anim_ctrl.
// Rev 1.0
`default_nettype none

package player_anim_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WALK    = 3'd1,
    AIR     = 3'd2,
    GOAL    = 3'd3,
    RESPAWN = 3'd4
  } anim_state_t;

  localparam logic [2:0] SPR_IDLE  = 3'd0;
  localparam logic [2:0] SPR_WALK0 = 3'd1;
  localparam logic [2:0] SPR_AIR   = 3'd4;
  localparam logic [2:0] SPR_GOAL  = 3'd5;

  // 10-bit position differences never reach -1024, so the negation cannot overflow.
  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    return v[10] ? 11'(-v) : 11'(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/player_anim_if.sv
// player_anim_if: movement-stage inputs and sprite-side outputs of the animation controller.
// Rev 1.0
`default_nettype none

interface player_anim_if;
  logic [9:0]  BallX;
  logic [9:0]  BallY;
  logic [20:0] logicalX;
  logic        lookDir;
  logic        endFlag;
  logic [2:0]  anim_state;
  logic [2:0]  sprite_idx;
  logic        flip_h;
  logic        visible;
  logic        step_pulse;

  modport master (
    output BallX, BallY, logicalX, lookDir, endFlag,
    input  anim_state, sprite_idx, flip_h, visible, step_pulse
  );

  modport slave (
    input  BallX, BallY, logicalX, lookDir, endFlag,
    output anim_state, sprite_idx, flip_h, visible, step_pulse
  );
endinterface

`default_nettype wire

// File: rtl/anim_motion_detect.sv
// anim_motion_detect: frame-to-frame position deltas, motion flags and respawn teleport detection.
// Rev 1.0
`default_nettype none

module anim_motion_detect
  import player_anim_pkg::*;
#(
  parameter int JUMP_DELTA = 20
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic [20:0] logical_x,
  output logic        h_move,
  output logic        v_move,
  output logic        teleport
);

  logic [9:0]  prev_x;
  logic [9:0]  prev_y;
  logic [20:0] prev_l;
  logic        prev_valid;

  logic signed [10:0] dx;
  logic signed [10:0] dy;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      prev_x     <= '0;
      prev_y     <= '0;
      prev_l     <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev_x     <= ball_x;
      prev_y     <= ball_y;
      prev_l     <= logical_x;
      prev_valid <= 1'b1;
    end
  end

  assign dx = $signed({1'b0, ball_x}) - $signed({1'b0, prev_x});
  assign dy = $signed({1'b0, ball_y}) - $signed({1'b0, prev_y});

  // Scrolling with the screen locked moves the player even though BallX stays put.
  assign h_move   = prev_valid && ((dx != 11'sd0) || (logical_x != prev_l));
  assign v_move   = prev_valid && (dy != 11'sd0);
  assign teleport = prev_valid && ((abs11(dx) > 11'(JUMP_DELTA)) ||
                                   (abs11(dy) > 11'(JUMP_DELTA)));

endmodule

`default_nettype wire

// File: rtl/player_anim_ctrl.sv
// player_anim_ctrl: per-frame animation FSM producing sprite index, flip, visibility and footstep pulse.
// Rev 1.0
`default_nettype none

module player_anim_ctrl
  import player_anim_pkg::*;
#(
  parameter int WALK_FRAMES = 3,
  parameter int WALK_DIV    = 6,
  parameter int STILL_HOLD  = 2,
  parameter int JUMP_DELTA  = 20,
  parameter int BLINK_LEN   = 60,
  parameter int BLINK_DIV   = 4
) (
  input  logic         frame_clk,
  input  logic         Reset,
  player_anim_if.slave bus
);

  localparam int DIV_W = (WALK_DIV    > 1) ? $clog2(WALK_DIV)    : 1;
  localparam int PH_W  = (WALK_FRAMES > 1) ? $clog2(WALK_FRAMES) : 1;
  localparam int STL_W = (STILL_HOLD  > 1) ? $clog2(STILL_HOLD)  : 1;
  localparam int BLK_W = (BLINK_LEN   > 1) ? $clog2(BLINK_LEN)   : 1;
  localparam int BDV_W = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;

  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(WALK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_MAX    = PH_W'(WALK_FRAMES - 1);
  localparam logic [STL_W-1:0] STILL_MAX = STL_W'(STILL_HOLD - 1);
  localparam logic [BLK_W-1:0] BLINK_MAX = BLK_W'(BLINK_LEN - 1);
  localparam logic [BDV_W-1:0] BDIV_MAX  = BDV_W'(BLINK_DIV - 1);

  logic h_move;
  logic v_move;
  logic teleport;

  anim_state_t      state;
  logic [2:0]       sprite_idx;
  logic             flip_h;
  logic             visible;
  logic             step_pulse;
  logic [DIV_W-1:0] div_cnt;
  logic [PH_W-1:0]  walk_ph;
  logic [STL_W-1:0] still_cnt;
  logic [BLK_W-1:0] blink_cnt;
  logic [BDV_W-1:0] bdiv_cnt;

  logic            div_wrap;
  logic [PH_W-1:0] ph_inc;

  anim_motion_detect #(
    .JUMP_DELTA (JUMP_DELTA)
  ) u_motion (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .ball_x    (bus.BallX),
    .ball_y    (bus.BallY),
    .logical_x (bus.logicalX),
    .h_move    (h_move),
    .v_move    (v_move),
    .teleport  (teleport)
  );

  assign div_wrap = (div_cnt == DIV_MAX);
  assign ph_inc   = (walk_ph == PH_MAX) ? '0 : walk_ph + PH_W'(1);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      sprite_idx <= SPR_IDLE;
      flip_h     <= 1'b0;
      visible    <= 1'b1;
      step_pulse <= 1'b0;
      div_cnt    <= '0;
      walk_ph    <= '0;
      still_cnt  <= '0;
      blink_cnt  <= '0;
      bdiv_cnt   <= '0;
    end else begin
      step_pulse <= 1'b0;
      flip_h     <= bus.lookDir;
      if (teleport) begin
        state      <= RESPAWN;
        sprite_idx <= SPR_IDLE;
        visible    <= 1'b0;
        blink_cnt  <= BLINK_MAX;
        bdiv_cnt   <= '0;
      end else if (state == RESPAWN) begin
        if (blink_cnt == '0) begin
          state   <= IDLE;
          visible <= 1'b1;
        end else begin
          blink_cnt <= blink_cnt - BLK_W'(1);
          if (bdiv_cnt == BDIV_MAX) begin
            bdiv_cnt <= '0;
            visible  <= ~visible;
          end else begin
            bdiv_cnt <= bdiv_cnt + BDV_W'(1);
          end
        end
      end else if (bus.endFlag) begin
        // Facing is frozen for the whole goal slide.
        state      <= GOAL;
        sprite_idx <= SPR_GOAL;
        visible    <= 1'b1;
        flip_h     <= flip_h;
      end else if (state == GOAL) begin
        state      <= IDLE;
        sprite_idx <= SPR_IDLE;
      end else if (v_move) begin
        state      <= AIR;
        sprite_idx <= SPR_AIR;
        still_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (h_move) begin
              state      <= WALK;
              sprite_idx <= SPR_WALK0;
              div_cnt    <= '0;
              walk_ph    <= '0;
              still_cnt  <= '0;
            end
          end
          WALK: begin
            if (div_wrap) begin
              div_cnt    <= '0;
              walk_ph    <= ph_inc;
              step_pulse <= 1'b1;
              sprite_idx <= SPR_WALK0 + 3'(ph_inc);
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
            if (h_move) begin
              still_cnt <= '0;
            end else if (still_cnt == STILL_MAX) begin
              state      <= IDLE;
              sprite_idx <= SPR_IDLE;
            end else begin
              still_cnt <= still_cnt + STL_W'(1);
            end
          end
          AIR: begin
            if (still_cnt == STILL_MAX) begin
              still_cnt <= '0;
              if (h_move) begin
                state      <= WALK;
                sprite_idx <= SPR_WALK0;
                div_cnt    <= '0;
                walk_ph    <= '0;
              end else begin
                state      <= IDLE;
                sprite_idx <= SPR_IDLE;
              end
            end else begin
              still_cnt <= still_cnt + STL_W'(1);
            end
          end
          default: begin
            state      <= IDLE;
            sprite_idx <= SPR_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.anim_state = state;
  assign bus.sprite_idx = sprite_idx;
  assign bus.flip_h     = flip_h;
  assign bus.visible    = visible;
  assign bus.step_pulse = step_pulse;

endmodule

`default_nettype wire

// File: tb/tb_player_anim_ctrl.sv
// tb_player_anim_ctrl: table vectors, hand sequences and randomized motion against a frame-level model.
// Rev 1.0
`default_nettype none

module tb_player_anim_ctrl;
  import player_anim_pkg::*;

  localparam int WALK_FRAMES = 3;
  localparam int WALK_DIV    = 6;
  localparam int STILL_HOLD  = 2;
  localparam int JUMP_DELTA  = 20;
  localparam int BLINK_LEN   = 60;
  localparam int BLINK_DIV   = 4;

  localparam int S_IDLE = 0;
  localparam int S_WALK = 1;
  localparam int S_AIR  = 2;
  localparam int S_GOAL = 3;
  localparam int S_RESP = 4;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b0;
  always #5 frame_clk = ~frame_clk;

  player_anim_if bus ();

  player_anim_ctrl #(
    .WALK_FRAMES (WALK_FRAMES),
    .WALK_DIV    (WALK_DIV),
    .STILL_HOLD  (STILL_HOLD),
    .JUMP_DELTA  (JUMP_DELTA),
    .BLINK_LEN   (BLINK_LEN),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Frame-level model: ages in frames rather than wrapped counters.
  int m_state, m_still, m_walk_age, m_resp_age;
  int m_px, m_py, m_pl;
  bit m_flip, m_step, m_pv;

  typedef struct {
    int bx; int by; int lx; bit look; bit endf;
    int st; int spr; bit flip; bit vis; bit step;
  } vec_t;

  vec_t tbl[19];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clamp10(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  function automatic vec_t mk(input int bx, by, lx, input bit look, endf,
                              input int st, spr, input bit flip, vis, step);
    vec_t r;
    r.bx = bx; r.by = by; r.lx = lx; r.look = look; r.endf = endf;
    r.st = st; r.spr = spr; r.flip = flip; r.vis = vis; r.step = step;
    return r;
  endfunction

  function automatic int m_sprite();
    if (m_state == S_WALK) return 1 + (m_walk_age / WALK_DIV) % WALK_FRAMES;
    if (m_state == S_AIR)  return 4;
    if (m_state == S_GOAL) return 5;
    return 0;
  endfunction

  function automatic bit m_visible();
    if (m_state == S_RESP) return ((m_resp_age / BLINK_DIV) % 2) == 1;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_still = 0; m_walk_age = 0; m_resp_age = 0;
    m_px = 0; m_py = 0; m_pl = 0; m_flip = 0; m_step = 0; m_pv = 0;
  endtask

  task automatic model_step(input int bx, by, lx, input bit look, endf);
    bit h, v, tp;
    int dx, dy;
    h = 0; v = 0; tp = 0;
    if (m_pv) begin
      dx = bx - m_px;
      dy = by - m_py;
      h  = (dx != 0) || (lx != m_pl);
      v  = (dy != 0);
      tp = (iabs(dx) > JUMP_DELTA) || (iabs(dy) > JUMP_DELTA);
    end
    m_step = 0;
    if (tp) begin
      m_state = S_RESP; m_resp_age = 0;
    end else if (m_state == S_RESP) begin
      if (m_resp_age == BLINK_LEN - 1) m_state = S_IDLE;
      else m_resp_age++;
    end else if (endf) begin
      m_state = S_GOAL;
    end else if (m_state == S_GOAL) begin
      m_state = S_IDLE;
    end else if (v) begin
      m_state = S_AIR; m_still = 0;
    end else if (m_state == S_IDLE) begin
      if (h) begin m_state = S_WALK; m_walk_age = 0; m_still = 0; end
    end else if (m_state == S_WALK) begin
      m_walk_age++;
      m_step = (m_walk_age % WALK_DIV) == 0;
      if (h) m_still = 0;
      else begin
        m_still++;
        if (m_still == STILL_HOLD) m_state = S_IDLE;
      end
    end else begin
      m_still++;
      if (m_still == STILL_HOLD) begin
        if (h) begin m_state = S_WALK; m_walk_age = 0; m_still = 0; end
        else m_state = S_IDLE;
      end
    end
    if (m_state != S_GOAL) m_flip = look;
    m_px = bx; m_py = by; m_pl = lx; m_pv = 1;
  endtask

  task automatic check(input string tag, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0d required=%0d", tag, name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, spr, input bit flip, vis, step);
    check(tag, "anim_state", int'(bus.anim_state), st);
    check(tag, "sprite_idx", int'(bus.sprite_idx), spr);
    check(tag, "flip_h",     int'(bus.flip_h),     int'(flip));
    check(tag, "visible",    int'(bus.visible),    int'(vis));
    check(tag, "step_pulse", int'(bus.step_pulse), int'(step));
  endtask

  task automatic check_model(input string tag);
    check_all(tag, m_state, m_sprite(), m_flip, m_visible(), m_step);
  endtask

  // Apply inputs, take one frame edge, then sample just after it.
  task automatic drive(input int bx, by, lx, input bit look, endf);
    bus.BallX    = 10'(bx);
    bus.BallY    = 10'(by);
    bus.logicalX = 21'(lx);
    bus.lookDir  = look;
    bus.endFlag  = endf;
    @(posedge frame_clk);
    model_step(bx, by, lx, look, endf);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    @(posedge frame_clk);
    #1 Reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int bx, by, lx, mode, left;
    bit look, endf;

    tbl[0]  = mk( 82, 360, 0, 0, 0, S_WALK, 1, 0, 1, 0);
    tbl[1]  = mk( 84, 360, 0, 0, 0, S_WALK, 1, 0, 1, 0);
    tbl[2]  = mk( 86, 360, 0, 0, 0, S_WALK, 1, 0, 1, 0);
    tbl[3]  = mk( 88, 360, 0, 0, 0, S_WALK, 1, 0, 1, 0);
    tbl[4]  = mk( 90, 360, 0, 0, 0, S_WALK, 1, 0, 1, 0);
    tbl[5]  = mk( 92, 360, 0, 0, 0, S_WALK, 1, 0, 1, 0);
    tbl[6]  = mk( 94, 360, 0, 0, 0, S_WALK, 2, 0, 1, 1);
    tbl[7]  = mk( 94, 360, 0, 0, 0, S_WALK, 2, 0, 1, 0);
    tbl[8]  = mk( 94, 360, 0, 0, 0, S_IDLE, 0, 0, 1, 0);
    tbl[9]  = mk( 94, 360, 1, 0, 0, S_WALK, 1, 0, 1, 0);
    tbl[10] = mk( 94, 360, 2, 1, 0, S_WALK, 1, 1, 1, 0);
    tbl[11] = mk( 94, 351, 2, 1, 0, S_AIR,  4, 1, 1, 0);
    tbl[12] = mk( 94, 351, 2, 1, 0, S_AIR,  4, 1, 1, 0);
    tbl[13] = mk( 94, 351, 2, 1, 0, S_IDLE, 0, 1, 1, 0);
    tbl[14] = mk( 94, 351, 2, 1, 1, S_GOAL, 5, 1, 1, 0);
    tbl[15] = mk( 94, 351, 2, 0, 1, S_GOAL, 5, 1, 1, 0);
    tbl[16] = mk( 94, 351, 2, 0, 0, S_IDLE, 0, 0, 1, 0);
    tbl[17] = mk(300, 351, 2, 0, 0, S_RESP, 0, 0, 0, 0);
    tbl[18] = mk(300, 351, 2, 0, 0, S_RESP, 0, 0, 0, 0);

    bus.BallX = 10'd80; bus.BallY = 10'd360; bus.logicalX = '0;
    bus.lookDir = 1'b0; bus.endFlag = 1'b0;
    #1 Reset = 1'b1;
    #1 check_all("reset", S_IDLE, 0, 0, 1, 0);
    @(posedge frame_clk);
    #1 Reset = 1'b0;
    model_reset();

    for (int k = 0; k < 10; k++) begin
      drive(80, 360, 0, 0, 0);
      check_all($sformatf("idle%0d", k), S_IDLE, 0, 0, 1, 0);
    end

    for (int k = 0; k < 19; k++) begin
      drive(tbl[k].bx, tbl[k].by, tbl[k].lx, tbl[k].look, tbl[k].endf);
      check_all($sformatf("vec%0d", k), tbl[k].st, tbl[k].spr, tbl[k].flip, tbl[k].vis, tbl[k].step);
    end

    // Rest of the blink period: four frames hidden, four shown, then back to IDLE.
    for (int k = 2; k < BLINK_LEN; k++) begin
      drive(300, 351, 2, 0, 0);
      check_all($sformatf("blink%0d", k), S_RESP, 0, 0, ((k / 4) % 2) == 1, 0);
    end
    drive(300, 351, 2, 0, 0);
    check_all("blink_end", S_IDLE, 0, 0, 1, 0);

    drive(80, 360, 2, 0, 1);
    check_all("tp_beats_end", S_RESP, 0, 0, 0, 0);
    drive(80, 360, 2, 0, 0);
    check_all("resp_hold", S_RESP, 0, 0, 0, 0);
    Reset = 1'b1;
    #1 check_all("reset_mid_resp", S_IDLE, 0, 0, 1, 0);
    @(posedge frame_clk);
    #1 Reset = 1'b0;
    model_reset();

    drive(80, 360, 0, 1, 0);
    drive(80, 360, 0, 1, 0);
    drive(82, 360, 0, 1, 0);
    check_all("walk_flip", S_WALK, 1, 1, 1, 0);
    drive(84, 360, 0, 1, 1);
    check_all("goal_enter", S_GOAL, 5, 1, 1, 0);
    drive(86, 360, 0, 0, 1);
    check_all("goal_frozen", S_GOAL, 5, 1, 1, 0);
    Reset = 1'b1;
    #1 check_all("reset_mid_goal", S_IDLE, 0, 0, 1, 0);
    @(posedge frame_clk);
    #1 Reset = 1'b0;
    model_reset();

    bx = 500; by = 240; lx = 0; look = 0; endf = 0; mode = 0; left = 0;
    for (int i = 0; i < 1200; i++) begin
      if (left == 0) begin
        mode = int'($urandom_range(0, 5));
        left = int'($urandom_range(2, 24));
      end
      left--;
      if ($urandom_range(0, 149) == 0) begin
        bx = int'($urandom_range(0, 1023));
        by = int'($urandom_range(0, 1023));
      end else begin
        case (mode)
          1: bx = clamp10(bx + int'($urandom_range(0, 6)) - 3);
          2: lx = lx + 1;
          3: by = clamp10(by + int'($urandom_range(0, 6)) - 3);
          4: begin
            bx = clamp10(bx + int'($urandom_range(0, 4)) - 2);
            by = clamp10(by + int'($urandom_range(0, 4)) - 2);
          end
          default: ;
        endcase
      end
      if ($urandom_range(0, 99) < 3) endf = ~endf;
      if ($urandom_range(0, 9) == 0) look = ~look;
      drive(bx, by, lx, look, endf);
      check_model($sformatf("rnd%0d", i));
      if (i == 600) begin
        pulse_reset();
        check_model("rnd_reset");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
